// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR coefficient sequencer.
// State encoding, default sizes and counter-width helper.
package fir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    FLUSH,
    RUN
  } state_t;

  localparam int NTAPS_DEF = 32;
  localparam int TW_DEF    = 16;
  localparam int IW_DEF    = 16;

  function automatic int cw_f(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fir_coeff_sequencer.sv
// Sequences coefficient load, delay-line flush and live sample gating
// for one FIR tap chain; sole driver of the chain's h/hr/CE inputs.
module fir_coeff_sequencer
  import fir_pkg::*;
#(
  parameter int TW    = TW_DEF,
  parameter int IW    = IW_DEF,
  parameter int NTAPS = NTAPS_DEF
) (
  input  logic          i_clk,
  input  logic          reset,
  input  logic          s_coeff_valid,
  output logic          s_coeff_ready,
  input  logic [TW-1:0] s_coeff_data,
  input  logic          s_coeff_last,
  input  logic          i_sample_valid,
  input  logic [IW-1:0] i_sample,
  output logic [IW-1:0] o_sample,
  output logic          o_sample_ce,
  output logic [TW-1:0] o_h,
  output logic          o_hr,
  output logic          o_busy,
  output logic          o_ready_run,
  output logic          o_err
);

  localparam int CW = cw_f(NTAPS);
  localparam logic [CW-1:0] LAST_IDX = CW'(NTAPS - 1);
  localparam logic [CW-1:0] FULL     = CW'(NTAPS);

  state_t        state;
  state_t        state_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] idx;
  logic [TW-1:0] h_d;
  logic [IW-1:0] smp_d;
  logic          hr_d;
  logic          ce_d;
  logic          err_d;
  logic          accept;

  // A beat arriving from IDLE or RUN is always beat 0 of a new set
  assign idx    = (state == LOAD) ? cnt : '0;
  assign accept = s_coeff_valid & s_coeff_ready;

  // Handshake and status flags decoded from the current state
  always_comb begin
    s_coeff_ready = 1'b0;
    o_busy        = 1'b0;
    o_ready_run   = 1'b0;
    unique case (state)
      IDLE:  s_coeff_ready = 1'b1;
      LOAD: begin
        s_coeff_ready = 1'b1;
        o_busy        = 1'b1;
      end
      DRAIN: begin
        s_coeff_ready = 1'b1;
        o_busy        = 1'b1;
      end
      FLUSH: o_busy = 1'b1;
      RUN: begin
        s_coeff_ready = !i_sample_valid;
        o_ready_run   = 1'b1;
      end
      default: ;
    endcase
  end

  // Next state, beat/flush counter and next values of registered outputs
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    h_d     = o_h;
    hr_d    = 1'b0;
    ce_d    = 1'b0;
    smp_d   = '0;
    err_d   = o_err;
    unique case (state)
      IDLE, LOAD, RUN: begin
        if (state == RUN) begin
          ce_d  = i_sample_valid;
          smp_d = i_sample;
        end
        if (accept) begin
          h_d   = s_coeff_data;
          hr_d  = 1'b1;
          cnt_d = '0;
          if (s_coeff_last) begin
            err_d = (idx != LAST_IDX);
            if (idx == LAST_IDX) state_d = FLUSH;
            else                 state_d = IDLE;
          end else if (idx == LAST_IDX) begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = LOAD;
            cnt_d   = (idx == FULL) ? idx : idx + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (accept && s_coeff_last) state_d = IDLE;
      end
      FLUSH: begin
        ce_d = 1'b1;
        if (cnt == LAST_IDX) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = (cnt == FULL) ? cnt : cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any partial set
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      o_h         <= '0;
      o_hr        <= 1'b0;
      o_sample_ce <= 1'b0;
      o_sample    <= '0;
      o_err       <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      o_h         <= h_d;
      o_hr        <= hr_d;
      o_sample_ce <= ce_d;
      o_sample    <= smp_d;
      o_err       <= err_d;
    end
  end

  hr_ce_excl: assert property (
    @(posedge i_clk) disable iff (reset) !(o_hr && o_sample_ce)
  );

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// Directed bench for fir_coeff_sequencer.
// Loads good and malformed coefficient sets and checks chain controls.
module tb_fir_coeff_sequencer;

  logic        clk;
  logic        reset;
  logic        s_coeff_valid;
  logic        s_coeff_ready;
  logic [15:0] s_coeff_data;
  logic        s_coeff_last;
  logic        i_sample_valid;
  logic [15:0] i_sample;
  logic [15:0] o_sample;
  logic        o_sample_ce;
  logic [15:0] o_h;
  logic        o_hr;
  logic        o_busy;
  logic        o_ready_run;
  logic        o_err;

  int checks = 0;
  int errors = 0;
  int hr_cnt = 0;
  int ce_cnt = 0;
  int ce_nz  = 0;
  int both   = 0;
  logic [15:0] h_log [64];

  fir_coeff_sequencer dut (
    .i_clk          (clk),
    .reset          (reset),
    .s_coeff_valid  (s_coeff_valid),
    .s_coeff_ready  (s_coeff_ready),
    .s_coeff_data   (s_coeff_data),
    .s_coeff_last   (s_coeff_last),
    .i_sample_valid (i_sample_valid),
    .i_sample       (i_sample),
    .o_sample       (o_sample),
    .o_sample_ce    (o_sample_ce),
    .o_h            (o_h),
    .o_hr           (o_hr),
    .o_busy         (o_busy),
    .o_ready_run    (o_ready_run),
    .o_err          (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (o_hr) begin
        if (hr_cnt < 64) h_log[hr_cnt] = o_h;
        hr_cnt++;
      end
      if (o_sample_ce) begin
        ce_cnt++;
        if (o_sample != 16'h0) ce_nz++;
      end
      if (o_hr && o_sample_ce) both++;
    end
  end

  task automatic clr_mon();
    #2;
    hr_cnt = 0;
    ce_cnt = 0;
    ce_nz  = 0;
    for (int i = 0; i < 64; i++) h_log[i] = 16'h0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic beat(input logic [15:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    s_coeff_valid = 1'b1;
    s_coeff_data  = d;
    s_coeff_last  = l;
    #1;
    while (!s_coeff_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("beat_rdy", 32'(s_coeff_ready), 32'd1);
    @(posedge clk);
    #1;
    s_coeff_valid = 1'b0;
    s_coeff_last  = 1'b0;
  endtask

  task automatic good_set();
    for (int i = 0; i < 32; i++) beat(16'(i + 1), i == 31);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic ok;
    reset          = 1'b1;
    s_coeff_valid  = 1'b0;
    s_coeff_data   = 16'h0;
    s_coeff_last   = 1'b0;
    i_sample_valid = 1'b0;
    i_sample       = 16'h0;
    wait_cyc(3);
    chk("rst_ready", 32'(s_coeff_ready), 32'd1);
    chk("rst_hr",    32'(o_hr),          32'd0);
    chk("rst_ce",    32'(o_sample_ce),   32'd0);
    chk("rst_busy",  32'(o_busy),        32'd0);
    chk("rst_run",   32'(o_ready_run),   32'd0);
    chk("rst_err",   32'(o_err),         32'd0);
    chk("rst_h",     32'(o_h),           32'd0);
    reset = 1'b0;
    wait_cyc(2);

    // 1: good 32-beat set
    clr_mon();
    good_set();
    wait_cyc(5);
    chk("t1_busy_fl", 32'(o_busy),        32'd1);
    chk("t1_rdy_fl",  32'(s_coeff_ready), 32'd0);
    chk("t1_ce_fl",   32'(o_sample_ce),   32'd1);
    chk("t1_smp_fl",  32'(o_sample),      32'd0);
    wait_cyc(40);
    chk("t1_hr_cnt", 32'(hr_cnt), 32'd32);
    ok = 1'b1;
    for (int i = 0; i < 32; i++) if (h_log[i] != 16'(i + 1)) ok = 1'b0;
    chk("t1_hseq",   32'(ok),          32'd1);
    chk("t1_h_last", 32'(h_log[31]),   32'd32);
    chk("t1_ce_cnt", 32'(ce_cnt),      32'd32);
    chk("t1_ce_nz",  32'(ce_nz),       32'd0);
    chk("t1_run",    32'(o_ready_run), 32'd1);
    chk("t1_busy",   32'(o_busy),      32'd0);
    chk("t1_err",    32'(o_err),       32'd0);

    // 2: live samples pass with one cycle latency
    for (int k = 0; k < 3; k++) begin
      logic [15:0] v;
      v = (k == 0) ? 16'h1234 : (k == 1) ? 16'h8001 : 16'h0F0F;
      @(negedge clk);
      i_sample_valid = 1'b1;
      i_sample       = v;
      #1;
      chk("t2_rdy_lo", 32'(s_coeff_ready), 32'd0);
      @(negedge clk);
      i_sample_valid = 1'b0;
      chk("t2_ce",  32'(o_sample_ce), 32'd1);
      chk("t2_smp", 32'(o_sample),    32'(v));
      @(negedge clk);
      chk("t2_ce_off", 32'(o_sample_ce), 32'd0);
      wait_cyc(1);
    end

    // 3: under-run then recovery
    clr_mon();
    for (int i = 0; i < 10; i++) beat(16'(16'h200 + i), i == 9);
    wait_cyc(5);
    chk("t3_err",    32'(o_err),       32'd1);
    chk("t3_busy",   32'(o_busy),      32'd0);
    chk("t3_run",    32'(o_ready_run), 32'd0);
    chk("t3_ce_cnt", 32'(ce_cnt),      32'd0);
    chk("t3_hr_cnt", 32'(hr_cnt),      32'd10);
    good_set();
    wait_cyc(40);
    chk("t3_err_clr", 32'(o_err),       32'd0);
    chk("t3_run2",    32'(o_ready_run), 32'd1);

    // 4: over-run of 40 beats
    clr_mon();
    for (int i = 0; i < 40; i++) beat(16'(i + 1), i == 39);
    wait_cyc(5);
    chk("t4_hr_cnt", 32'(hr_cnt),      32'd32);
    chk("t4_h_last", 32'(h_log[31]),   32'd32);
    chk("t4_err",    32'(o_err),       32'd1);
    chk("t4_busy",   32'(o_busy),      32'd0);
    chk("t4_run",    32'(o_ready_run), 32'd0);
    chk("t4_ce_cnt", 32'(ce_cnt),      32'd0);

    // 5: sample and beat collide in RUN
    good_set();
    wait_cyc(40);
    chk("t5_run0", 32'(o_ready_run), 32'd1);
    @(negedge clk);
    s_coeff_valid  = 1'b1;
    s_coeff_data   = 16'h0055;
    s_coeff_last   = 1'b0;
    i_sample_valid = 1'b1;
    i_sample       = 16'hBEEF;
    #1;
    chk("t5_rdy_lo", 32'(s_coeff_ready), 32'd0);
    @(negedge clk);
    chk("t5_ce",  32'(o_sample_ce), 32'd1);
    chk("t5_smp", 32'(o_sample),    32'hBEEF);
    chk("t5_run", 32'(o_ready_run), 32'd1);
    chk("t5_hr0", 32'(o_hr),        32'd0);
    i_sample_valid = 1'b0;
    #1;
    chk("t5_rdy_hi", 32'(s_coeff_ready), 32'd1);
    @(negedge clk);
    s_coeff_valid = 1'b0;
    chk("t5_busy", 32'(o_busy),      32'd1);
    chk("t5_hr",   32'(o_hr),        32'd1);
    chk("t5_h",    32'(o_h),         32'h0055);
    chk("t5_ce0",  32'(o_sample_ce), 32'd0);

    // 6: asynchronous reset at beat 15
    for (int i = 1; i < 15; i++) beat(16'(16'h300 + i), 1'b0);
    chk("t6_busy_pre", 32'(o_busy), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_hr",    32'(o_hr),          32'd0);
    chk("t6_h",     32'(o_h),           32'd0);
    chk("t6_busy",  32'(o_busy),        32'd0);
    chk("t6_ce",    32'(o_sample_ce),   32'd0);
    chk("t6_ready", 32'(s_coeff_ready), 32'd1);
    chk("t6_err",   32'(o_err),         32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_cyc(3);
    chk("t6_idle_busy", 32'(o_busy),      32'd0);
    chk("t6_idle_run",  32'(o_ready_run), 32'd0);
    clr_mon();
    good_set();
    wait_cyc(40);
    chk("t6_hr_cnt", 32'(hr_cnt),      32'd32);
    chk("t6_run",    32'(o_ready_run), 32'd1);
    chk("t6_err2",   32'(o_err),       32'd0);
    chk("hr_ce_both", 32'(both),       32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
